// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM port arbiter.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_PVR = 1'b1
  } owner_e;

  // Read data returned when a read times out (VRAM_ARB_TIMEOUT_EN builds only).
  localparam logic [63:0] TIMEOUT_FILL = 64'hDEADBEEF_DEADBEEF;

  // VRAM is 64-bit wide, so byte-lane bits [2:0] never reach the port.
  localparam logic [23:0] ADDR_ALIGN_MASK = 24'hFFFFF8;

  function automatic logic [23:0] align_addr(input logic [23:0] a);
    return a & ADDR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester and VRAM-controller signal bundle for vram_arbiter.
// slave: the arbiter's view. master: the surrounding system's view.
interface vram_arbiter_if;

  logic        cpu_req;
  logic        cpu_wr;
  logic [23:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic        cpu_done;
  logic [63:0] cpu_rdata;

  logic        pvr_req;
  logic        pvr_wr;
  logic [23:0] pvr_addr;
  logic [63:0] pvr_wdata;
  logic        pvr_done;
  logic [63:0] pvr_rdata;

  logic        vram_rd;
  logic        vram_wr;
  logic [23:0] vram_addr;
  logic [63:0] vram_dout;
  logic [63:0] vram_din;
  logic        vram_wait;
  logic        vram_valid;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_done, cpu_rdata,
    input  pvr_req, pvr_wr, pvr_addr, pvr_wdata,
    output pvr_done, pvr_rdata,
    output vram_rd, vram_wr, vram_addr, vram_dout,
    input  vram_din, vram_wait, vram_valid
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_done, cpu_rdata,
    output pvr_req, pvr_wr, pvr_addr, pvr_wdata,
    input  pvr_done, pvr_rdata,
    input  vram_rd, vram_wr, vram_addr, vram_dout,
    output vram_din, vram_wait, vram_valid
  );

endinterface

// File: rtl/vram_arb_pick.sv
// Winner selection for the VRAM arbiter: PVR has priority, but after
// PVR_STREAK consecutive PVR grants with the CPU waiting, the CPU wins once.
module vram_arb_pick
  import vram_arb_pkg::*;
#(
  parameter int unsigned PVR_STREAK = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   eval_i,
  input  logic   cpu_req_i,
  input  logic   pvr_req_i,
  output logic   grant_o,
  output owner_e owner_o
);

  localparam int unsigned    SW         = $clog2(PVR_STREAK + 1);
  localparam logic [SW-1:0]  STREAK_MAX = SW'(PVR_STREAK);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;

  // Pick the winner from the live requests and the current streak.
  always_comb begin
    grant_o = cpu_req_i | pvr_req_i;
    owner_o = OWN_CPU;
    if (pvr_req_i && !(cpu_req_i && (streak_q == STREAK_MAX))) begin
      owner_o = OWN_PVR;
    end
  end

  // Streak counts PVR wins taken while the CPU was kept waiting.
  always_comb begin
    streak_d = streak_q;
    if (eval_i && grant_o) begin
      if ((owner_o == OWN_PVR) && cpu_req_i) begin
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end
  end

  // Streak register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single PVR VRAM port between the SH4 (CS1 window) and the PVR
// fetch engine, one transaction at a time.
// Optional: define VRAM_ARB_TIMEOUT_EN to add a read-response timeout and
// the sticky err_timeout output.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned PVR_STREAK = 4
`ifdef VRAM_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic           clk,
  input  logic           rst,
  vram_arbiter_if.slave  bus,
  output logic           busy,
  output logic           err_spurious
`ifdef VRAM_ARB_TIMEOUT_EN
  , output logic         err_timeout
`endif
);

  state_e      state_q;
  owner_e      owner_q;
  logic        wr_q;
  logic [23:0] addr_q;
  logic [63:0] wdata_q;
  logic        vram_rd_q;
  logic        vram_wr_q;
  logic        cpu_done_q;
  logic        pvr_done_q;
  logic [63:0] cpu_rdata_q;
  logic [63:0] pvr_rdata_q;
  logic        err_spur_q;

`ifdef VRAM_ARB_TIMEOUT_EN
  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          err_tmo_q;
`endif

  logic        grant;
  owner_e      win_owner;
  logic        sel_wr;
  logic [23:0] sel_addr;
  logic [63:0] sel_wdata;

  vram_arb_pick #(
    .PVR_STREAK (PVR_STREAK)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .eval_i    (state_q == IDLE),
    .cpu_req_i (bus.cpu_req),
    .pvr_req_i (bus.pvr_req),
    .grant_o   (grant),
    .owner_o   (win_owner)
  );

  // Route the winning requester's qualifiers toward the command registers.
  always_comb begin
    sel_wr    = bus.cpu_wr;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    if (win_owner == OWN_PVR) begin
      sel_wr    = bus.pvr_wr;
      sel_addr  = bus.pvr_addr;
      sel_wdata = bus.pvr_wdata;
    end
  end

  // Transaction sequencer with registered strobes, done pulses and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      vram_rd_q   <= 1'b0;
      vram_wr_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      pvr_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      pvr_rdata_q <= '0;
      err_spur_q  <= 1'b0;
`ifdef VRAM_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      err_tmo_q   <= 1'b0;
`endif
    end else begin
      cpu_done_q <= 1'b0;
      pvr_done_q <= 1'b0;
      if (bus.vram_valid && (state_q != RDWAIT)) begin
        err_spur_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (grant) begin
            owner_q   <= win_owner;
            wr_q      <= sel_wr;
            addr_q    <= align_addr(sel_addr);
            wdata_q   <= sel_wdata;
            vram_rd_q <= ~sel_wr;
            vram_wr_q <= sel_wr;
            state_q   <= CMD;
          end
        end
        CMD: begin
          if (!bus.vram_wait) begin
            vram_rd_q <= 1'b0;
            vram_wr_q <= 1'b0;
            if (wr_q) begin
              if (owner_q == OWN_PVR) pvr_done_q <= 1'b1;
              else                    cpu_done_q <= 1'b1;
              state_q <= IDLE;
            end else begin
`ifdef VRAM_ARB_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
              state_q <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          if (bus.vram_valid) begin
            if (owner_q == OWN_PVR) begin
              pvr_rdata_q <= bus.vram_din;
              pvr_done_q  <= 1'b1;
            end else begin
              cpu_rdata_q <= bus.vram_din;
              cpu_done_q  <= 1'b1;
            end
            state_q <= IDLE;
          end
`ifdef VRAM_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            if (owner_q == OWN_PVR) begin
              pvr_rdata_q <= TIMEOUT_FILL;
              pvr_done_q  <= 1'b1;
            end else begin
              cpu_rdata_q <= TIMEOUT_FILL;
              cpu_done_q  <= 1'b1;
            end
            err_tmo_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.vram_rd   = vram_rd_q;
  assign bus.vram_wr   = vram_wr_q;
  assign bus.vram_addr = addr_q;
  assign bus.vram_dout = wdata_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.pvr_done  = pvr_done_q;
  assign bus.pvr_rdata = pvr_rdata_q;
  assign busy          = (state_q != IDLE);
  assign err_spurious  = err_spur_q;
`ifdef VRAM_ARB_TIMEOUT_EN
  assign err_timeout   = err_tmo_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with hand-computed literal expectations.
// Define VRAM_ARB_TIMEOUT_EN to also exercise the read timeout.
module tb_vram_arbiter;

  localparam int STREAK = 4;
`ifdef VRAM_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic err_spurious;
`ifdef VRAM_ARB_TIMEOUT_EN
  logic err_timeout;
`endif

  vram_arbiter_if bus();

  vram_arbiter #(
    .PVR_STREAK (STREAK)
`ifdef VRAM_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TMO)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .err_spurious (err_spurious)
`ifdef VRAM_ARB_TIMEOUT_EN
    , .err_timeout (err_timeout)
`endif
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    bit          pvr;
    bit          wr;
    logic [23:0] addr;
    logic [63:0] data;
  } txn_t;

  txn_t        cur[$];        // the one outstanding transaction, if any
  txn_t        t;
  bit          m_acc;         // command accepted, read data still owed
  int          m_run;         // PVR wins in a row with the CPU waiting
  int          m_waited;
  bit          m_cpu_done, m_pvr_done, m_spur, m_tmo;
  logic [63:0] m_cpu_rd = '0;
  logic [63:0] m_pvr_rd = '0;

  task automatic model_complete(input logic [63:0] rdata, input bit is_read);
    if (cur[0].pvr) begin
      m_pvr_done = 1'b1;
      if (is_read) m_pvr_rd = rdata;
    end else begin
      m_cpu_done = 1'b1;
      if (is_read) m_cpu_rd = rdata;
    end
    void'(cur.pop_front());
    m_acc = 1'b0;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      cur.delete();
      m_acc = 0; m_run = 0; m_waited = 0;
      m_cpu_done = 0; m_pvr_done = 0; m_spur = 0; m_tmo = 0;
      m_cpu_rd = '0; m_pvr_rd = '0;
    end else begin
      m_cpu_done = 0;
      m_pvr_done = 0;
      if (bus.vram_valid && !((cur.size() != 0) && m_acc)) m_spur = 1;
      if (cur.size() == 0) begin
        if (bus.pvr_req && (!bus.cpu_req || (m_run < STREAK))) begin
          t.pvr = 1'b1; t.wr = bus.pvr_wr;
          t.addr = bus.pvr_addr & 24'hFFFFF8; t.data = bus.pvr_wdata;
          m_run = bus.cpu_req ? m_run + 1 : 0;
          cur.push_back(t);
        end else if (bus.cpu_req) begin
          t.pvr = 1'b0; t.wr = bus.cpu_wr;
          t.addr = bus.cpu_addr & 24'hFFFFF8; t.data = bus.cpu_wdata;
          m_run = 0;
          cur.push_back(t);
        end
        m_acc = 0;
      end else if (!m_acc) begin
        if (!bus.vram_wait) begin
          if (cur[0].wr) model_complete('0, 1'b0);
          else begin m_acc = 1; m_waited = 0; end
        end
      end else begin
        if (bus.vram_valid) model_complete(bus.vram_din, 1'b1);
`ifdef VRAM_ARB_TIMEOUT_EN
        else begin
          m_waited++;
          if (m_waited == TMO) begin
            model_complete(64'hDEADBEEF_DEADBEEF, 1'b1);
            m_tmo = 1;
          end
        end
`endif
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  bit m_cmd, m_wr;
  initial forever begin
    @(negedge clk);
    m_cmd = (cur.size() != 0) && !m_acc;
    m_wr  = (cur.size() != 0) ? cur[0].wr : 1'b0;
    check("busy",     64'(busy),          64'(cur.size() != 0));
    check("vram_rd",  64'(bus.vram_rd),   64'(m_cmd && !m_wr));
    check("vram_wr",  64'(bus.vram_wr),   64'(m_cmd && m_wr));
    if (m_cmd) begin
      check("vram_addr", 64'(bus.vram_addr), 64'(cur[0].addr));
      if (m_wr) check("vram_dout", bus.vram_dout, cur[0].data);
    end
    check("cpu_done",  64'(bus.cpu_done), 64'(m_cpu_done));
    check("pvr_done",  64'(bus.pvr_done), 64'(m_pvr_done));
    check("cpu_rdata", bus.cpu_rdata,     m_cpu_rd);
    check("pvr_rdata", bus.pvr_rdata,     m_pvr_rd);
    check("err_spurious", 64'(err_spurious), 64'(m_spur));
`ifdef VRAM_ARB_TIMEOUT_EN
    check("err_timeout", 64'(err_timeout), 64'(m_tmo));
`endif
  end

  // ---------------- VRAM controller responder ----------------
  int          cfg_wait = 0;     // stall cycles per command
  int          cfg_vdelay = 0;   // cycles from read accept to valid; 0 = never
  logic [63:0] cfg_din = '0;
  bit          spur_pulse = 0;
  bit          rd_acc_s = 0;
  bit          vpend = 0;
  int          stall = 0;
  int          vcnt = 0;

  initial forever begin
    @(negedge clk);
    rd_acc_s = bus.vram_rd && !bus.vram_wait;
  end

  initial begin
    bus.vram_wait  = 1'b0;
    bus.vram_valid = 1'b0;
    bus.vram_din   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        stall = 0; vpend = 0;
        bus.vram_wait = 1'b0; bus.vram_valid = 1'b0;
      end else begin
        if (rd_acc_s && (cfg_vdelay != 0)) begin vpend = 1; vcnt = cfg_vdelay; end
        bus.vram_valid = 1'b0;
        if (vpend) begin
          if (vcnt <= 1) begin
            bus.vram_valid = 1'b1; bus.vram_din = cfg_din; vpend = 0;
          end else vcnt--;
        end
        if (spur_pulse) begin bus.vram_valid = 1'b1; spur_pulse = 0; end
        if (bus.vram_rd || bus.vram_wr) begin
          if (stall < cfg_wait) begin bus.vram_wait = 1'b1; stall++; end
          else bus.vram_wait = 1'b0;
        end else begin
          stall = 0; bus.vram_wait = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  int          n, done_at, got;
  logic [9:0]  order;

  initial begin
    bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.pvr_req = 0; bus.pvr_wr = 0; bus.pvr_addr = '0; bus.pvr_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  64'(busy),          64'd0);
    check("rst_rd",    64'(bus.vram_rd),   64'd0);
    check("rst_wr",    64'(bus.vram_wr),   64'd0);
    check("rst_addr",  64'(bus.vram_addr), 64'd0);
    check("rst_cdone", 64'(bus.cpu_done),  64'd0);
    check("rst_pdone", 64'(bus.pvr_done),  64'd0);
    check("rst_spur",  64'(err_spurious),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: CPU-only zero-wait write
    cfg_wait = 0; cfg_vdelay = 0;
    bus.cpu_req = 1; bus.cpu_wr = 1; bus.cpu_addr = 24'h000108;
    bus.cpu_wdata = 64'h1122334455667788;
    @(negedge clk);
    check("t1_vram_wr",  64'(bus.vram_wr),   64'd1);
    check("t1_addr",     64'(bus.vram_addr), 64'h000108);
    check("t1_dout",     bus.vram_dout,      64'h1122334455667788);
    check("t1_no_done",  64'(bus.cpu_done),  64'd0);
    @(negedge clk);
    check("t1_cpu_done", 64'(bus.cpu_done),  64'd1);
    check("t1_wr_drop",  64'(bus.vram_wr),   64'd0);
    check("t1_idle",     64'(busy),          64'd0);
    bus.cpu_req = 0;
    @(negedge clk);
    check("t1_one_pulse", 64'(bus.cpu_done), 64'd0);

    // 2: PVR read, 3 stall cycles, valid two cycles after accept
    cfg_wait = 3; cfg_vdelay = 2; cfg_din = 64'hA5A5A5A5A5A5A5A5;
    bus.pvr_req = 1; bus.pvr_wr = 0; bus.pvr_addr = 24'h002A0F;
    n = 0; done_at = 0;
    for (int c = 1; (c <= 40) && (done_at == 0); c++) begin
      @(negedge clk);
      if (bus.vram_rd) begin
        n++;
        check("t2_addr_hold", 64'(bus.vram_addr), 64'h002A08);
      end
      if (bus.pvr_done) done_at = c;
    end
    bus.pvr_req = 0;
    check("t2_rd_cycles", 64'(n),        64'd4);
    check("t2_done_cyc",  64'(done_at),  64'd7);
    check("t2_rdata",     bus.pvr_rdata, 64'hA5A5A5A5A5A5A5A5);
    @(negedge clk);

    // 3: both requesting continuously, single-cycle VRAM writes
    cfg_wait = 0;
    bus.cpu_req = 1; bus.cpu_wr = 1; bus.cpu_addr = 24'h000100; bus.cpu_wdata = 64'hC0C0C0C0C0C0C0C0;
    bus.pvr_req = 1; bus.pvr_wr = 1; bus.pvr_addr = 24'hFFFFFF; bus.pvr_wdata = 64'h5050505050505050;
    got = 0; order = '0;
    for (int c = 0; (c < 80) && (got < 10); c++) begin
      @(negedge clk);
      if (bus.pvr_done || bus.cpu_done) begin
        order = {order[8:0], bus.pvr_done};
        got++;
        if (got == 10) begin bus.cpu_req = 0; bus.pvr_req = 0; end
      end
    end
    bus.cpu_req = 0; bus.pvr_req = 0;
    check("t3_count", 64'(got),   64'd10);
    check("t3_order", 64'(order), 64'(10'b1111011110));
    repeat (2) @(negedge clk);

    // 4: spurious valid while idle
    spur_pulse = 1;
    repeat (3) @(negedge clk);
    check("t4_spur",    64'(err_spurious), 64'd1);
    check("t4_idle",    64'(busy),         64'd0);
    check("t4_nodone",  64'(bus.cpu_done | bus.pvr_done), 64'd0);
    repeat (2) @(negedge clk);
    check("t4_sticky",  64'(err_spurious), 64'd1);

    // 5a: reset while a read command is stalled
    cfg_wait = 100; cfg_vdelay = 0;
    bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 24'h000400;
    @(negedge clk);
    check("t5a_rd_before", 64'(bus.vram_rd), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t5a_rd_async",   64'(bus.vram_rd), 64'd0);
    check("t5a_busy_async", 64'(busy),        64'd0);
    bus.cpu_req = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 5b: reset in the read-wait phase, then a normal read
    cfg_wait = 0; cfg_vdelay = 50;
    bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 24'h000400;
    repeat (3) @(negedge clk);
    check("t5b_busy_pre", 64'(busy),        64'd1);
    check("t5b_rd_pre",   64'(bus.vram_rd), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("t5b_busy_async", 64'(busy),         64'd0);
    check("t5b_nodone",     64'(bus.cpu_done), 64'd0);
    bus.cpu_req = 0;
    @(negedge clk);
    check("t5b_spur_clr", 64'(err_spurious), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    cfg_wait = 1; cfg_vdelay = 1; cfg_din = 64'h0123456789ABCDEF;
    bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 24'h000808;
    done_at = 0;
    for (int c = 1; (c <= 30) && (done_at == 0); c++) begin
      @(negedge clk);
      if (bus.cpu_done) done_at = c;
    end
    bus.cpu_req = 0;
    check("t5_after_done_cyc", 64'(done_at),  64'd4);
    check("t5_after_rdata",    bus.cpu_rdata, 64'h0123456789ABCDEF);
    repeat (2) @(negedge clk);

`ifdef VRAM_ARB_TIMEOUT_EN
    // 6: read never answered
    cfg_wait = 0; cfg_vdelay = 0;
    bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 24'h000C00;
    done_at = 0;
    for (int c = 1; (c <= 30) && (done_at == 0); c++) begin
      @(negedge clk);
      if (bus.cpu_done) done_at = c;
    end
    bus.cpu_req = 0;
    check("t6_done_cyc", 64'(done_at),     64'd10);
    check("t6_rdata",    bus.cpu_rdata,    64'hDEADBEEF_DEADBEEF);
    check("t6_err_tmo",  64'(err_timeout), 64'd1);
    check("t6_spur_pre", 64'(err_spurious), 64'd0);
    spur_pulse = 1;
    repeat (2) @(negedge clk);
    check("t6_late_valid", 64'(err_spurious), 64'd1);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
